// File: rtl/rv_pkg.sv
// Shared types and LFSR helper for the 8-bit ready/valid stream master and slave.
// Both ends use the same data-generation rule.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } rv_state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3 of the current word
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rv_lfsr.sv
// 8-bit Fibonacci LFSR data source; a zero seed is replaced by 0x01 so the
// register never locks up.
module rv_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] q
);

  import rv_pkg::*;

  logic [7:0] r_q;

  // Load wins over advance; both never happen together in the master
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 8'h00;
    end else if (load) begin
      r_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (advance) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ready_valid_master.sv
// Ready/valid stream master: sends a burst of LFSR bytes with optional idle gaps,
// honours backpressure and flags a slave that stalls too long.
module ready_valid_master #(
  parameter int RV_MAX_SVL_NOT_READY = 0,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic [7:0]           seed,
  input  logic [3:0]           gap_cycles,
  input  logic                 slave_ready,
  output logic [7:0]           data,
  output logic                 master_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  import rv_pkg::*;

  // Wide enough that the saturated value always exceeds the limit
  localparam int STALL_W = (RV_MAX_SVL_NOT_READY > 0) ? $clog2(RV_MAX_SVL_NOT_READY + 2) : 1;
  localparam logic [31:0] STALL_LIMIT = RV_MAX_SVL_NOT_READY;

  rv_state_e            r_state;
  logic [CNT_WIDTH-1:0] r_numWords;
  logic [CNT_WIDTH-1:0] r_beatCnt;
  logic [3:0]           r_gap;
  logic [3:0]           r_gapCnt;
  logic [STALL_W-1:0]   r_stallCnt;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_timeoutErr;

  logic                 w_transfer;
  logic                 w_lastBeat;
  logic                 w_lfsrLoad;
  logic [7:0]           w_lfsrQ;

  assign w_transfer = r_valid & slave_ready;
  assign w_lastBeat = (r_beatCnt == (r_numWords - CNT_WIDTH'(1)));
  assign w_lfsrLoad = (r_state == IDLE) & start & (num_words != '0);

  rv_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_lfsrLoad),
    .seed    (seed),
    .advance (w_transfer),
    .q       (w_lfsrQ)
  );

  // Burst sequencer; every output is a flop so valid never follows ready combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_numWords   <= '0;
      r_beatCnt    <= '0;
      r_gap        <= '0;
      r_gapCnt     <= '0;
      r_stallCnt   <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeoutErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_timeoutErr <= 1'b0;
            r_numWords   <= num_words;
            r_gap        <= gap_cycles;
            r_beatCnt    <= '0;
            r_gapCnt     <= '0;
            r_stallCnt   <= '0;
            if (num_words == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= SEND;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (w_transfer) begin
            r_stallCnt <= '0;
            if (w_lastBeat) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_beatCnt <= r_beatCnt + CNT_WIDTH'(1);
              if (r_gap != 4'd0) begin
                r_state  <= GAP;
                r_valid  <= 1'b0;
                r_gapCnt <= 4'd0;
              end
            end
          end else begin
            if (r_stallCnt != '1) begin
              r_stallCnt <= r_stallCnt + STALL_W'(1);
            end
            // This stall is one past the tolerated run length
            if ((RV_MAX_SVL_NOT_READY > 0) && (32'(r_stallCnt) >= STALL_LIMIT)) begin
              r_timeoutErr <= 1'b1;
            end
          end
        end

        GAP: begin
          if (r_gapCnt == (r_gap - 4'd1)) begin
            r_state <= SEND;
            r_valid <= 1'b1;
          end else begin
            r_gapCnt <= r_gapCnt + 4'd1;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign data         = w_lfsrQ;
  assign master_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_timeoutErr;

endmodule

// File: tb/tb_ready_valid_master.sv
// Bench for ready_valid_master: table-driven bursts, a mid-burst reset sequence and
// randomized bursts checked by a beat-level stream model.
module tb_ready_valid_master;

  localparam int MAX_STALL = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] num_words;
  logic [7:0] seed;
  logic [3:0] gap_cycles;
  logic       slave_ready;
  logic [7:0] data;
  logic       master_valid;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  ready_valid_master #(
    .RV_MAX_SVL_NOT_READY (MAX_STALL),
    .CNT_WIDTH            (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_words    (num_words),
    .seed         (seed),
    .gap_cycles   (gap_cycles),
    .slave_ready  (slave_ready),
    .data         (data),
    .master_valid (master_valid),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    int         num;
    int         gap;
    int         stall;
    bit         noisy;
    logic [7:0] expFirst;
    int         expDoneCyc;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [7:0] modelNext(input logic [7:0] d);
    logic fb;
    fb = d[7] ^ d[5] ^ d[4] ^ d[3];
    return {d[6:0], fb};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one burst and checks every cycle against the expected stream of beats
  task automatic applyStimulus(input logic [7:0] s, input int n, input int g, input int stallFirst,
                               input bit randReady, input bit noisy,
                               output int doneCyc, output logic [7:0] firstWord);
    logic [7:0] words[16];
    int  k, lowRemain, stallRun, cyc, stallLeft;
    bit  prevValid, prevReady, expValid, pendingDone, finished, expTimeout, seenFirst;

    words[0] = (s == 8'h00) ? 8'h01 : s;
    for (int i = 1; i < 16; i++) words[i] = modelNext(words[i-1]);

    @(negedge clk);
    seed        = s;
    num_words   = 4'(n);
    gap_cycles  = 4'(g);
    start       = 1'b1;
    slave_ready = 1'b1;

    k = 0; lowRemain = 0; stallRun = 0; cyc = 0; stallLeft = stallFirst;
    prevValid = 1'b0; prevReady = 1'b1; pendingDone = (n == 0); finished = 1'b0;
    expTimeout = 1'b0; seenFirst = 1'b0; doneCyc = 0; firstWord = 8'h00;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prevValid && prevReady) begin
        k++;
        lowRemain = g;
        stallRun  = 0;
        if (k == n) pendingDone = 1'b1;
      end else if (prevValid) begin
        stallRun++;
        if (stallRun > MAX_STALL) expTimeout = 1'b1;
      end
      expValid = (k < n) && (lowRemain == 0);

      checkOutput("valid", 32'(master_valid), 32'(expValid));
      if (expValid) checkOutput($sformatf("data_beat%0d", k), 32'(data), 32'(words[k]));
      checkOutput("busy", 32'(busy), 32'(k < n));
      checkOutput("done", 32'(done), 32'(pendingDone));
      checkOutput("timeout_err", 32'(timeout_err), 32'(expTimeout));

      if (expValid && !seenFirst) begin
        firstWord = data;
        seenFirst = 1'b1;
      end
      if (pendingDone) begin
        doneCyc  = cyc;
        finished = 1'b1;
      end
      if (!expValid && lowRemain > 0) lowRemain--;

      if (expValid && k == 0 && stallLeft > 0) begin
        slave_ready = 1'b0;
        stallLeft--;
      end else begin
        slave_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      prevValid = expValid;
      prevReady = slave_ready;

      start = noisy && !finished;
      if (start) begin
        seed       = 8'($urandom);
        num_words  = 4'($urandom_range(1, 15));
        gap_cycles = 4'($urandom);
      end
    end

    if (!finished) checkOutput("burst_budget", 32'd0, 32'd1);
    start       = 1'b0;
    slave_ready = 1'b1;
    @(negedge clk);
    checkOutput("after_done_done", 32'(done), 32'd0);
    checkOutput("after_done_busy", 32'(busy), 32'd0);
    checkOutput("after_done_valid", 32'(master_valid), 32'd0);
  endtask

  initial begin
    int         doneCyc, doneSeen, n, g, st, expCyc;
    bit         rr, nz;
    logic [7:0] firstWord;

    //           seed   num gap stall noisy first doneCyc
    vecs[0]  = '{8'h01,  4,  0,  0,   0,   8'h01,  5};
    vecs[1]  = '{8'h01,  3,  2,  0,   0,   8'h01,  8};
    vecs[2]  = '{8'h00,  2,  0,  0,   0,   8'h01,  3};
    vecs[3]  = '{8'h80,  3,  1,  0,   0,   8'h80,  6};
    vecs[4]  = '{8'hFF,  2,  0,  0,   0,   8'hFF,  3};
    vecs[5]  = '{8'h01,  1,  5,  0,   0,   8'h01,  2};
    vecs[6]  = '{8'h5A,  0,  3,  0,   0,   8'h00,  1};
    vecs[7]  = '{8'h01, 15,  0,  0,   0,   8'h01, 16};
    vecs[8]  = '{8'h01,  2,  0,  5,   0,   8'h01,  8};
    vecs[9]  = '{8'h01,  3,  0,  4,   0,   8'h01,  8};
    vecs[10] = '{8'h01,  2,  0,  3,   0,   8'h01,  6};
    vecs[11] = '{8'h01,  3,  1,  0,   1,   8'h01,  6};

    rst_n = 1'b0; start = 1'b0; num_words = '0; seed = '0; gap_cycles = '0; slave_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'd0);
    checkOutput("reset_valid", 32'(master_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].seed, vecs[i].num, vecs[i].gap, vecs[i].stall, 1'b0, vecs[i].noisy,
                    doneCyc, firstWord);
      checkOutput($sformatf("vec%0d_first", i), 32'(firstWord), 32'(vecs[i].expFirst));
      checkOutput($sformatf("vec%0d_donecyc", i), 32'(doneCyc), 32'(vecs[i].expDoneCyc));
    end

    // Reset while beat 2 of 8 is on the bus
    @(negedge clk);
    seed = 8'h01; num_words = 4'd8; gap_cycles = 4'd0; start = 1'b1; slave_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_beat0", 32'(data), 32'h01);
    @(negedge clk);
    checkOutput("rst_beat1", 32'(data), 32'h02);
    @(negedge clk);
    checkOutput("rst_beat2", 32'(data), 32'h04);
    checkOutput("rst_beat2_valid", 32'(master_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(master_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || master_valid) doneSeen++;
    end
    checkOutput("midrst_quiet", 32'(doneSeen), 32'd0);
    applyStimulus(8'h01, 3, 0, 0, 1'b0, 1'b0, doneCyc, firstWord);
    checkOutput("restart_first", 32'(firstWord), 32'h01);
    checkOutput("restart_donecyc", 32'(doneCyc), 32'd4);

    for (int r = 0; r < 24; r++) begin
      n  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 6));
      g  = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 5));
      rr = 1'($urandom_range(0, 1));
      nz = 1'($urandom_range(0, 1));
      applyStimulus(8'($urandom), n, g, st, rr, nz, doneCyc, firstWord);
      if (!rr) begin
        expCyc = (n == 0) ? 1 : (n + (n - 1) * g + st + 1);
        checkOutput($sformatf("rand%0d_donecyc", r), 32'(doneCyc), 32'(expCyc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
